// File: rtl/mp3_pkg.sv
// mp3_pkg: definitions shared across the MP3 bitstream front end.
//   bitrd_state_t : bit reader FSM state (IDLE / RUN)
//   BITBUF_W      : width of the left-aligned bit buffer
//   BITS_N_W      : width of a bit-field request length (0..32)
//   LEVEL_W       : width of the buffer fill level (0..64)
package mp3_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } bitrd_state_t;

   localparam int BITBUF_W = 64;
   localparam int BITS_N_W = 6;
   localparam int LEVEL_W  = 7;

endpackage

// File: rtl/mp3_bitbuf.sv
// mp3_bitbuf: 64-bit left-aligned shift/insert buffer.
// Bit 63 is the next stream bit. Each cycle the buffer drops i_take bits
// from the top and, when i_ins_en is set, appends a 32-bit word directly
// below the bits that remain after that drop.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   i_clr       : synchronous clear (stream restart), wins over take/insert
//   i_take      : bits consumed this cycle (never more than o_level)
//   i_ins_en    : append i_ins_word this cycle
//   i_ins_word  : word to append, MSB first
//   o_top       : upper 32 bits of the buffer (next 32 stream bits)
//   o_level     : number of valid bits held (0..64)
module mp3_bitbuf
   import mp3_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_clr,
   input  logic [LEVEL_W-1:0] i_take,
   input  logic               i_ins_en,
   input  logic [31:0]        i_ins_word,
   output logic [31:0]        o_top,
   output logic [LEVEL_W-1:0] o_level
);

   logic [BITBUF_W-1:0] r_buf;
   logic [LEVEL_W-1:0]  r_level;

   logic [LEVEL_W-1:0]  w_level_after;
   logic [BITBUF_W-1:0] w_buf_shift;
   logic [BITBUF_W-1:0] w_ins;

   // Bits below the valid level are always zero, so a shifted-in word can
   // simply be OR-ed in under whatever survives this cycle's consumption.
   assign w_level_after = r_level - i_take;
   assign w_buf_shift   = r_buf << i_take;
   assign w_ins         = {i_ins_word, 32'h0} >> w_level_after;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_buf   <= '0;
         r_level <= '0;
      end else begin
         r_buf   <= w_buf_shift | (i_ins_en ? w_ins : '0);
         r_level <= w_level_after + (i_ins_en ? 7'd32 : 7'd0);
      end
   end

   assign o_top   = r_buf[63:32];
   assign o_level = r_level;

endmodule

// File: rtl/mp3_bit_reader.sv
// mp3_bit_reader: bitstream front end for the MP3 decoder.
// Fetches 32-bit words from the source ROM (registered address, one-cycle
// read latency), buffers them in mp3_bitbuf and serves MSB-first bit fields
// of 0..32 bits, byte alignment and end-of-stream signalling.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start, start_addr     : pulse to (re)start streaming at start_addr
//   end_addr              : last valid word address, inclusive
//   rom_addr, rom_data    : ROM read port (data valid one cycle after addr)
//   bits_req, bits_n      : bit-field request and width (0..32)
//   align_req             : discard bits up to the next byte boundary
//   bits_ready            : request accepted this cycle (combinational)
//   bits_valid, bits_data : one-cycle result strobe, right-aligned field
//   bits_consumed         : bits consumed since start (wraps)
//   busy                  : FSM is in RUN
//   eos                   : stream exhausted, sticky until start/rst
//
// Handshake: a request (bits_req or align_req, never both) is held until
// bits_ready is high; the request is consumed on that clock edge. A bits_req
// acceptance produces bits_valid/bits_data on the following cycle; an
// align_req acceptance produces no result strobe.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mp3_bit_reader
   import mp3_pkg::*;
#(
   parameter int ADDR_W = `ADDRESS_WIDTH,
   parameter int DATA_W = `DATA_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [ADDR_W-1:0]   start_addr,
   input  logic [ADDR_W-1:0]   end_addr,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [DATA_W-1:0]   rom_data,
   input  logic                bits_req,
   input  logic [BITS_N_W-1:0] bits_n,
   input  logic                align_req,
   output logic                bits_ready,
   output logic                bits_valid,
   output logic [31:0]         bits_data,
   output logic [31:0]         bits_consumed,
   output logic                busy,
   output logic                eos
);

   bitrd_state_t        r_state;
   // One extra bit so the counter can step past end_addr without wrapping.
   logic [ADDR_W:0]     r_fetch_addr;
   logic [ADDR_W-1:0]   r_rom_addr;
   logic                r_v0;   // address issued, ROM still reading
   logic                r_v1;   // rom_data valid this cycle
   logic                r_valid;
   logic [31:0]         r_data;
   logic [31:0]         r_consumed;
   logic                r_eos;

   logic [31:0]         w_top;
   logic [LEVEL_W-1:0]  w_level;
   logic [1:0]          w_inflight;
   logic                w_exhausted;
   logic                w_drained;
   logic [BITS_N_W-1:0] w_n;
   logic [LEVEL_W-1:0]  w_n_ext;
   logic                w_ready;
   logic                w_accept;
   logic                w_short;
   logic [LEVEL_W-1:0]  w_take;
   logic                w_issue;
   logic [7:0]          w_fill;
   logic [31:0]         w_field;
   logic [BITS_N_W-1:0] w_rshift;

   assign w_inflight  = {1'b0, r_v0} + {1'b0, r_v1};
   assign w_exhausted = r_fetch_addr > {1'b0, end_addr};
   assign w_drained   = w_exhausted && (w_inflight == 2'd0);

   // Alignment length is (8 - consumed mod 8) mod 8, i.e. -consumed mod 8.
   assign w_n     = align_req ? {3'b000, 3'd0 - r_consumed[2:0]} : bits_n;
   assign w_n_ext = {1'b0, w_n};

   assign w_ready  = (r_state == RUN) && (bits_req || align_req) &&
                     ((w_level >= w_n_ext) || w_drained);
   // A simultaneous start restarts the stream, so the request is dropped.
   assign w_accept = w_ready && !start;
   assign w_short  = w_accept && (w_level < w_n_ext);
   assign w_take   = !w_accept ? '0 : (w_short ? w_level : w_n_ext);

   // Keep buffered plus in-flight data within one word of headroom so a
   // returning word always fits below what is left in the buffer.
   assign w_fill  = {1'b0, w_level} + {1'b0, w_inflight, 5'b0};
   assign w_issue = (r_state == RUN) && !start && !w_exhausted &&
                    (w_fill <= 8'd32);

   // Missing low bits on a short read come out as zero because the buffer
   // is zero below its level.
   assign w_rshift = 6'd32 - w_n;
   assign w_field  = (w_n == '0) ? 32'h0 : (w_top >> w_rshift);

   mp3_bitbuf u_bitbuf (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (start),
      .i_take     (w_take),
      .i_ins_en   (r_v1),
      .i_ins_word (rom_data[31:0]),
      .o_top      (w_top),
      .o_level    (w_level)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_fetch_addr <= '0;
         r_rom_addr   <= '0;
         r_v0         <= 1'b0;
         r_v1         <= 1'b0;
         r_valid      <= 1'b0;
         r_data       <= '0;
         r_consumed   <= '0;
         r_eos        <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (start) begin
            r_state      <= RUN;
            r_fetch_addr <= {1'b0, start_addr};
            r_v0         <= 1'b0;
            r_v1         <= 1'b0;
            r_consumed   <= '0;
            r_eos        <= 1'b0;
         end else if (r_state == RUN) begin
            r_v0 <= w_issue;
            r_v1 <= r_v0;
            if (w_issue) begin
               r_rom_addr   <= r_fetch_addr[ADDR_W-1:0];
               r_fetch_addr <= r_fetch_addr + 1'b1;
            end
            if (w_accept) begin
               r_consumed <= r_consumed + {26'h0, w_n};
               if (bits_req) begin
                  r_valid <= 1'b1;
                  r_data  <= w_field;
               end
            end
            if (w_short || (w_drained && (w_level == '0))) begin
               r_eos   <= 1'b1;
               r_state <= IDLE;
            end
         end
      end
   end

   assign rom_addr      = r_rom_addr;
   assign bits_ready    = w_ready;
   assign bits_valid    = r_valid;
   assign bits_data     = r_data;
   assign bits_consumed = r_consumed;
   assign busy          = (r_state == RUN);
   assign eos           = r_eos;

endmodule
